instr_sequencer: RTL

//   Fetch/decode/issue control for the 8-bit processor.

---
 rtl/instr_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/issue sequencer for the 8-bit processor
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int IW      = 16,
  parameter int TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  output logic [3:0]      ctr1,
  output logic [2:0]      radd1,
  output logic [2:0]      radd2,
  output logic [7:0]      imm,
  output logic            exec_start,
  input  logic            exec_done,
  output logic            busy,
  output logic            halted,
  output logic            timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next;
  logic [IW-1:0]     ir, ir_next;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
  logic              to_q, to_next;
  logic              issuing;

  // State, PC, instruction register, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ir       <= ir_next;
      wait_cnt <= wait_cnt_next;
      to_q     <= to_next;
    end
  end

  // Next-state logic; instruction boundaries re-check run before fetching again
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ir_next       = ir;
    wait_cnt_next = wait_cnt;
    to_next       = to_q;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // decode straight off the memory data; IR only holds it for issue
        ir_next = imem_rdata;
        case (imem_rdata[15:12])
          OP_NOP: begin
            pc_next    = pc + PC_W'(1);
            state_next = run ? S_FETCH : S_IDLE;
          end
          OP_JMP: begin
            pc_next    = PC_W'(imem_rdata[7:0]);
            state_next = run ? S_FETCH : S_IDLE;
          end
          OP_HALT: begin
            state_next = S_HALT;
          end
          default: begin
            state_next = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        wait_cnt_next = '0;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_next = wait_cnt + CNT_W'(1);
        // a completion in the final cycle still counts as success
        if (exec_done) begin
          pc_next    = pc + PC_W'(1);
          state_next = run ? S_FETCH : S_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          to_next    = 1'b1;
          pc_next    = pc + PC_W'(1);
          state_next = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Execute-unit fields are forced to zero outside ISSUE/WAIT so nothing fires spuriously
  always_comb begin
    issuing     = (state == S_ISSUE) || (state == S_WAIT);
    ctr1        = issuing ? ir[15:12] : 4'b0000;
    radd1       = issuing ? ir[11:9]  : 3'b000;
    radd2       = issuing ? ir[8:6]   : 3'b000;
    imm         = issuing ? ir[7:0]   : 8'h00;
    exec_start  = (state == S_ISSUE);
    busy        = (state != S_IDLE) && (state != S_HALT);
    halted      = (state == S_HALT);
    timeout_err = to_q;
    imem_addr   = pc;
  end

endmodule
